// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO; mult/div results commit after a fixed busy latency.
// Optional divider: define MDU_DIV_EN to build div/divu, otherwise they are no-ops.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      prod_s, prod_u;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

`ifdef MDU_DIV_EN
  logic        div_signed, neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Sign-magnitude division: the most negative dividend over -1 yields 0x80000000 naturally.
  assign div_signed = (bus.op == OP_DIV);
  assign neg_a      = div_signed & bus.A[31];
  assign neg_b      = div_signed & bus.B[31];
  assign a_mag      = neg_a ? -bus.A : bus.A;
  assign b_mag      = (bus.B == 32'd0) ? 32'd1 : (neg_b ? -bus.B : bus.B);
  assign q_mag      = a_mag / b_mag;
  assign r_mag      = a_mag % b_mag;

  always_comb begin
    quo = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem = neg_a ? -r_mag : r_mag;
    if (bus.B == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = bus.A;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
`endif
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // HI/LO stay untouched until the counter expires, then the pending pair lands at once.
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, reset/stall sequences, random ops vs. arithmetic model.
module tb_mdu_unit;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mdu_if bus ();

  mdu_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  vec_t        vecs[10];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Architectural result of one issue, computed with 64-bit integer arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    lat = 0;
    case (op)
      3'd1: begin {hi, lo} = 64'(sa * sb); lat = MULT_CYCLES; end
      3'd2: begin {hi, lo} = ua * ub;      lat = MULT_CYCLES; end
      3'd3, 3'd4: begin
        if (DIV_ON) begin
          lat = DIV_CYCLES;
          if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
          end else if (op == 3'd3) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
          end else begin
            lo = 32'(ua / ub);
            hi = 32'(ua % ub);
          end
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Issue one op, count busy cycles (scrambling operands meanwhile), then check the committed pair.
  task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input int exp_lat);
    int cycles = 0;
    bit held = 1'b1;
    apply_stimulus(op, a, b);
    @(negedge clk);
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (bus.HI !== model_hi || bus.LO !== model_lo) held = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      @(negedge clk);
    end
    check_output({name, " busy_cycles"}, 32'(cycles), 32'(exp_lat));
    if (exp_lat > 0) check_output({name, " hold_during_run"}, 32'(held), 32'd1);
    check_output({name, " HI"}, bus.HI, exp_hi);
    check_output({name, " LO"}, bus.LO, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit rose;
    bit seen_busy;
    int lat;
    logic [31:0] eh, el;

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_CYCLES};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MULT_CYCLES};
    vecs[2] = DIV_ON ? '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES}
                     : '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 0};
    vecs[3] = DIV_ON ? '{3'd4, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, DIV_CYCLES}
                     : '{3'd4, 32'd5, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 0};
    vecs[4] = DIV_ON ? '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_CYCLES}
                     : '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0};
    vecs[5] = '{3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, DIV_ON ? 32'h8000_0000 : 32'hFFFF_FFFE, 0};
    vecs[6] = '{3'd6, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[7] = '{3'd0, 32'h5555_5555, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[8] = '{3'd7, 32'h5555_5555, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[9] = DIV_ON ? '{3'd3, 32'd10, 32'd3, 32'h0000_0001, 32'h0000_0003, DIV_CYCLES}
                     : '{3'd3, 32'd10, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0};

    // Reset values while reset is held low.
    repeat (2) @(negedge clk);
    check_output("reset busy", 32'(bus.busy), 32'd0);
    check_output("reset HI", bus.HI, 32'd0);
    check_output("reset LO", bus.LO, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Back-to-back mthi/mtlo: busy must never rise.
    rose = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'h1111_2222;
    @(negedge clk);
    rose |= bus.busy;
    bus.op = 3'd6; bus.A = 32'h3333_4444;
    @(negedge clk);
    rose |= bus.busy;
    bus.start = 1'b0; bus.op = 3'd0;
    @(negedge clk);
    rose |= bus.busy;
    check_output("mthi_mtlo busy_rose", 32'(rose), 32'd0);
    check_output("mthi_mtlo HI", bus.HI, 32'h1111_2222);
    check_output("mthi_mtlo LO", bus.LO, 32'h3333_4444);

    // mult in flight, mtlo during busy cycle 2 is ignored, reset in cycle 3 discards the result.
    apply_stimulus(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = 3'd0;
    @(negedge clk);
    check_output("stall busy_cycle3", 32'(bus.busy), 32'd1);
    check_output("stall mtlo_ignored LO", bus.LO, 32'h3333_4444);
    reset = 1'b0;
    #1;
    check_output("async_reset busy", 32'(bus.busy), 32'd0);
    check_output("async_reset HI", bus.HI, 32'd0);
    check_output("async_reset LO", bus.LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = 3'd0;
    check_output("first_edge_accept HI", bus.HI, 32'h0000_ABCD);
    seen_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_busy |= bus.busy;
    end
    check_output("no_commit_after_reset busy", 32'(seen_busy), 32'd0);
    check_output("no_commit_after_reset HI", bus.HI, 32'h0000_ABCD);
    check_output("no_commit_after_reset LO", bus.LO, 32'd0);
    model_hi = 32'h0000_ABCD;
    model_lo = 32'd0;

    // Random ops against the arithmetic model, with boundary operands mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      eh = model_hi;
      el = model_lo;
      ref_model(op, a, b, eh, el, lat);
      run_and_check($sformatf("rand%0d op%0d", i, op), op, a, b, eh, el, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
- REQ-001: Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
- REQ-002: Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  one clock; reset is asynchronous and active-low.
- REQ-005: start  input  1  issue strobe from EX stage, qualifies op/A/B.
- REQ-006: op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- REQ-007: A  input  32  first operand (forwarded GRF read port 1).
- REQ-008: B  input  32  second operand (forwarded GRF read port 2).
- REQ-009: busy  output  1  registered; high while a mult/div is in flight.
- REQ-010: HI  output  32  architectural HI register.
- REQ-011: LO  output  32  architectural LO register.

Function
- REQ-012: States IDLE and RUN; an accept occurs at a rising edge in IDLE with start=1 and op in 1..6.
- REQ-013: mult/multu accept: signed/unsigned 64-bit product of A,B latched into pending registers; counter loaded with MULT_CYCLES; state goes to RUN; busy=1 from the next cycle.
- REQ-014: div/divu accept: signed/unsigned quotient and remainder latched into pending registers; counter loaded with DIV_CYCLES; state goes to RUN.
- REQ-015: In RUN, counter decrements each cycle; on the edge where it reaches 0, HI/LO take the pending values, busy drops, and the state returns to IDLE.
- REQ-016: busy therefore stays high for exactly MULT_CYCLES or DIV_CYCLES cycles; new HI/LO are visible in the first cycle busy is low.
- REQ-017: HI/LO keep their old values throughout RUN; no partial results are exposed.
- REQ-018: mult/multu commit: HI = product[63:32], LO = product[31:0].
- REQ-019: div/divu commit: LO = quotient, HI = remainder; signed remainder takes the sign of the dividend (truncating division).
- REQ-020: Divide by zero (B=0): LO = 32'hFFFFFFFF, HI = A; full busy latency still applies.
- REQ-021: Signed overflow (A=32'h80000000, B=32'hFFFFFFFF, div): LO = 32'h80000000, HI = 0.
- REQ-022: mthi/mtlo accept: HI (or LO) = A at that edge; busy stays 0; the other register is unchanged.
- REQ-023: start while busy=1 is ignored entirely; the upstream stall logic must hold the instruction.
- REQ-024: start with op 0 or 7 is a no-op.
- REQ-025: Operands are sampled only at accept; A/B changes during RUN have no effect.

Reset
- REQ-026: While reset=0, asynchronously: HI=0, LO=0, busy=0, counter=0, pending registers cleared, state IDLE.
- REQ-027: Reset during RUN discards the pending result; no commit follows.
- REQ-028: After reset is released, the first edge may accept a start.

Configuration
- REQ-029: Macro MDU_DIV_EN defined: div/divu behave as REQ-014..REQ-021.
- REQ-030: Macro MDU_DIV_EN undefined: no divider logic is built; div/divu accepts are no-ops; busy stays 0 and HI/LO are unchanged.

Verification
- REQ-031: mult, A=32'hFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
- REQ-032: multu, A=32'hFFFFFFFF, B=2 -> HI=1, LO=32'hFFFFFFFE after 5 busy cycles.
- REQ-033: div, A=-7 (32'hFFFFFFF9), B=2 -> busy for 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu with B=0, A=5 -> LO=32'hFFFFFFFF, HI=5.
- REQ-034: mthi A=32'h12345678, then next cycle mtlo A=32'h9ABCDEF0 -> HI=32'h12345678, LO=32'h9ABCDEF0, busy never rises.
- REQ-035: mult started, then mtlo start in busy cycle 2, then reset=0 in cycle 3 -> mtlo ignored, busy=0 and HI=LO=0 immediately, no later commit.
- REQ-036: Build without MDU_DIV_EN: div A=10, B=3 -> busy=0 and HI/LO unchanged.
